// File: rtl/filt_cici_mc_pkg.sv
// ----------------------------------------------------------------------------
// filt_cici_mc_pkg
// Shared types and helper functions for the multi-channel CIC interpolator.
//   state_t     : LOAD (collect one frame of channel samples) / EMIT (interpolate)
//   idx_width   : channel index width, at least one bit
//   rate_width  : width of the runtime rate port
//   oup_width   : default output width including CIC bit growth
//   clamp_rate  : maps an out-of-range rate (0 or > max) onto the maximum rate
//   out_slot    : output phase that carries the comb sample, clamped to rate-1
// ----------------------------------------------------------------------------
package filt_cici_mc_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rate_width(input int max_rate);
        return $clog2(max_rate + 1);
    endfunction

    function automatic int oup_width(input int inp_width, input int order,
                                     input int max_rate, input int diff_delay);
        return inp_width + order * $clog2(max_rate * diff_delay);
    endfunction

    function automatic int clamp_rate(input int rate, input int max_rate);
        if (rate == 0 || rate > max_rate) return max_rate;
        return rate;
    endfunction

    function automatic int out_slot(input int phase, input int rate);
        return (phase < rate - 1) ? phase : rate - 1;
    endfunction

endpackage

// File: rtl/filt_cici_mc_if.sv
// ----------------------------------------------------------------------------
// filt_cici_mc_if
// Input/output stream bundle of the CIC interpolator.
//   i_ena              : global enable
//   i_rate             : interpolation factor, latched at channel-0 accept
//   i_data/i_valid     : input sample stream, o_ready back to the source
//   o_data/o_chan      : output sample and its channel
//   o_valid/i_ready    : output handshake with the downstream sink
// Modport slave is the filter's view, master is the environment's view.
// ----------------------------------------------------------------------------
interface filt_cici_mc_if
    import filt_cici_mc_pkg::*;
#(
    parameter int gp_nr_channels = 2,
    parameter int gp_max_rate    = 8,
    parameter int gp_inp_width   = 8,
    parameter int gp_oup_width   = 17
);
    localparam int CW = idx_width(gp_nr_channels);
    localparam int RW = rate_width(gp_max_rate);

    logic                    i_ena;
    logic [RW-1:0]           i_rate;
    logic [gp_inp_width-1:0] i_data;
    logic                    i_valid;
    logic                    o_ready;
    logic [gp_oup_width-1:0] o_data;
    logic [CW-1:0]           o_chan;
    logic                    o_valid;
    logic                    i_ready;

    modport slave (
        input  i_ena, i_rate, i_data, i_valid, i_ready,
        output o_ready, o_data, o_chan, o_valid
    );

    modport master (
        output i_ena, i_rate, i_data, i_valid, i_ready,
        input  o_ready, o_data, o_chan, o_valid
    );

endinterface

// File: rtl/cici_chan_regfile.sv
// ----------------------------------------------------------------------------
// cici_chan_regfile
// Per-channel state storage: one row of gp_words words per channel, cleared by
// the asynchronous reset. A single index selects the row that is read
// (combinationally) and, when i_wr_en is high, overwritten at the clock edge.
//   i_clk, i_rst_an : clock, asynchronous active-low reset
//   i_idx           : channel row selected this cycle
//   o_rd_row        : current contents of the selected row
//   i_wr_en/i_wr_row: write-back of the selected row
// ----------------------------------------------------------------------------
module cici_chan_regfile
    import filt_cici_mc_pkg::*;
#(
    parameter int gp_nr_channels = 2,
    parameter int gp_words       = 1,
    parameter int gp_width       = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_an,
    input  logic [idx_width(gp_nr_channels)-1:0]  i_idx,
    output logic [gp_words-1:0][gp_width-1:0]     o_rd_row,
    input  logic                                  i_wr_en,
    input  logic [gp_words-1:0][gp_width-1:0]     i_wr_row
);

    logic [gp_words-1:0][gp_width-1:0] mem [gp_nr_channels];

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int c = 0; c < gp_nr_channels; c++) mem[c] <= '0;
        end else if (i_wr_en) begin
            mem[i_idx] <= i_wr_row;
        end
    end

    assign o_rd_row = mem[i_idx];

endmodule

// File: rtl/filt_cici_mc.sv
// ----------------------------------------------------------------------------
// filt_cici_mc
// Multi-channel runtime-rate CIC interpolator. A frame of gp_nr_channels TDM
// samples is accepted (one comb pass per channel), then rate*gp_nr_channels
// interpolated samples are emitted in slot order ch = k mod N, phase = k div N.
//   i_clk    : single clock
//   i_rst_an : asynchronous active-low reset
//   bus      : stream bundle (filt_cici_mc_if.slave), see the interface file
// All arithmetic wraps modulo 2^gp_oup_width; comb and integrator wrap cancel.
// ----------------------------------------------------------------------------
module filt_cici_mc
    import filt_cici_mc_pkg::*;
#(
    parameter int gp_nr_channels = 2,
    parameter int gp_order       = 3,
    parameter int gp_diff_delay  = 1,
    parameter int gp_max_rate    = 8,
    parameter int gp_phase       = 0,
    parameter int gp_inp_width   = 8,
    parameter int gp_oup_width   = oup_width(gp_inp_width, gp_order, gp_max_rate, gp_diff_delay)
) (
    input  logic          i_clk,
    input  logic          i_rst_an,
    filt_cici_mc_if.slave bus
);

    localparam int CW     = idx_width(gp_nr_channels);
    localparam int RW     = rate_width(gp_max_rate);
    localparam int OW     = gp_oup_width;
    localparam int M      = gp_diff_delay;
    // Comb row: gp_order*M delay taps followed by the latest comb output.
    localparam int CWORDS = gp_order * M + 1;
    localparam int CO_IDX = gp_order * M;
    localparam logic [CW-1:0] LAST_CH = CW'(gp_nr_channels - 1);

    state_t              state, next_state;
    logic [CW-1:0]       ch_cnt;
    logic [RW-1:0]       phase_cnt, rate_q, slot_phase;
    logic                last_done;
    logic                ready, accept, advance, emit_step, last_slot;
    logic [OW-1:0]       o_data_q;
    logic [CW-1:0]       o_chan_q;
    logic                o_valid_q;
    logic [CWORDS-1:0][OW-1:0]   comb_rd, comb_wr;
    logic [gp_order-1:0][OW-1:0] integ_rd, integ_wr;
    logic [OW-1:0]       comb_x  [gp_order+1];
    logic [OW-1:0]       integ_x [gp_order+1];

    // State register
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) state <= ST_LOAD;
        else           state <= next_state;
    end

    // Next state: a frame ends once the last slot has been issued and the
    // sink has taken it.
    always_comb begin
        next_state = state;
        case (state)
            ST_LOAD: if (accept && ch_cnt == LAST_CH) next_state = ST_EMIT;
            ST_EMIT: if (last_done && advance)        next_state = ST_LOAD;
            default: next_state = ST_LOAD;
        endcase
    end

    // Control outputs; o_ready is forced low while reset is held.
    always_comb begin
        ready      = (state == ST_LOAD) && bus.i_ena && i_rst_an;
        accept     = ready && bus.i_valid;
        advance    = bus.i_ena && (!o_valid_q || bus.i_ready);
        emit_step  = (state == ST_EMIT) && !last_done && advance;
        last_slot  = (ch_cnt == LAST_CH) && (phase_cnt == rate_q - RW'(1));
        slot_phase = RW'(out_slot(gp_phase, int'(rate_q)));
    end

    // Comb chain for the accepted sample, and integrator chain for the
    // current emit slot; both read and rewrite the row of channel ch_cnt.
    always_comb begin
        comb_x[0] = {{(OW - gp_inp_width){bus.i_data[gp_inp_width-1]}}, bus.i_data};
        comb_wr   = comb_rd;
        for (int s = 0; s < gp_order; s++) begin
            comb_x[s+1]    = comb_x[s] - comb_rd[s*M + M - 1];
            comb_wr[s*M]   = comb_x[s];
            for (int j = 1; j < M; j++) comb_wr[s*M + j] = comb_rd[s*M + j - 1];
        end
        comb_wr[CO_IDX] = comb_x[gp_order];

        integ_x[0] = (phase_cnt == slot_phase) ? comb_rd[CO_IDX] : '0;
        integ_wr   = integ_rd;
        for (int s = 0; s < gp_order; s++) begin
            integ_x[s+1] = integ_rd[s] + integ_x[s];
            integ_wr[s]  = integ_x[s+1];
        end
    end

    // Channel/phase counters, frame rate and the registered output stage.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            ch_cnt    <= '0;
            phase_cnt <= '0;
            rate_q    <= RW'(gp_max_rate);
            last_done <= 1'b0;
            o_data_q  <= '0;
            o_chan_q  <= '0;
            o_valid_q <= 1'b0;
        end else if (accept) begin
            if (ch_cnt == '0) rate_q <= RW'(clamp_rate(int'(bus.i_rate), gp_max_rate));
            ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CW'(1);
        end else if (emit_step) begin
            o_data_q  <= integ_x[gp_order];
            o_chan_q  <= ch_cnt;
            o_valid_q <= 1'b1;
            if (ch_cnt == LAST_CH) begin
                ch_cnt <= '0;
                if (last_slot) begin
                    phase_cnt <= '0;
                    last_done <= 1'b1;
                end else begin
                    phase_cnt <= phase_cnt + RW'(1);
                end
            end else begin
                ch_cnt <= ch_cnt + CW'(1);
            end
        end else if (state == ST_EMIT && last_done && advance) begin
            o_valid_q <= 1'b0;
            last_done <= 1'b0;
        end
    end

    cici_chan_regfile #(
        .gp_nr_channels (gp_nr_channels),
        .gp_words       (CWORDS),
        .gp_width       (OW)
    ) u_comb_rf (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_idx    (ch_cnt),
        .o_rd_row (comb_rd),
        .i_wr_en  (accept),
        .i_wr_row (comb_wr)
    );

    cici_chan_regfile #(
        .gp_nr_channels (gp_nr_channels),
        .gp_words       (gp_order),
        .gp_width       (OW)
    ) u_integ_rf (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_idx    (ch_cnt),
        .o_rd_row (integ_rd),
        .i_wr_en  (emit_step),
        .i_wr_row (integ_wr)
    );

    assign bus.o_ready = ready;
    assign bus.o_data  = o_data_q;
    assign bus.o_chan  = o_chan_q;
    assign bus.o_valid = o_valid_q;

endmodule
